// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: default widths and FSM states.
package count_seq_pkg;

    localparam int unsigned DEFAULT_VW = 3;
    localparam int unsigned DEFAULT_CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Control/status bundle between a sequencer client (master) and the sequencer (slave).
interface count_sequencer_if
    import count_seq_pkg::*;
#(
    parameter int unsigned VW = DEFAULT_VW,
    parameter int unsigned CW = DEFAULT_CW
);

    logic          start;
    logic          stop;
    logic          clear;
    logic          dir;
    logic [VW-1:0] modulus;
    logic [CW-1:0] wrap_target;
    logic [VW-1:0] value;
    logic [CW-1:0] wrap_count;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, stop, clear, dir, modulus, wrap_target,
        input  value, wrap_count, busy, done, err
    );

    modport slave (
        input  start, stop, clear, dir, modulus, wrap_target,
        output value, wrap_count, busy, done, err
    );

endinterface

// File: rtl/count_sequencer_mod_counter.sv
// Modulo-N up/down counter with synchronous load and a combinational wrap strobe.
module mod_counter
    import count_seq_pkg::*;
#(
    parameter int unsigned VW = DEFAULT_VW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          enable_i,
    input  logic          load_i,
    input  logic          dir_i,
    input  logic [VW-1:0] modulus_i,
    output logic [VW-1:0] value_o,
    output logic          wrap_o
);

    logic [VW-1:0] value_q;
    logic [VW-1:0] value_d;
    logic [VW-1:0] top_val;
    logic          at_term;

    assign top_val = modulus_i - VW'(1);
    assign at_term = dir_i ? (value_q == '0) : (value_q == top_val);
    assign wrap_o  = enable_i && !load_i && at_term;
    assign value_o = value_q;

    // Next value: load start point, otherwise step with wrap at the terminal value
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = dir_i ? top_val : '0;
        end else if (enable_i) begin
            if (at_term) begin
                value_d = dir_i ? top_val : '0;
            end else begin
                value_d = dir_i ? (value_q - VW'(1)) : (value_q + VW'(1));
            end
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/done sequencer around a modulo counter, counting wraps toward a target.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned VW = DEFAULT_VW,
    parameter int unsigned CW = DEFAULT_CW
) (
    input  logic             clock,
    input  logic             reset,
    count_sequencer_if.slave bus
);

    state_t        state_q, state_d;
    logic [CW-1:0] wc_q, wc_d;
    logic          dir_q, dir_d;
    logic [VW-1:0] mod_q, mod_d;
    logic [CW-1:0] tgt_q, tgt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          cnt_en;
    logic          cnt_load;
    logic          cnt_dir;
    logic [VW-1:0] cnt_mod;
    logic [VW-1:0] cnt_value;
    logic          cnt_wrap;
    logic [CW-1:0] wc_inc;

    assign wc_inc = wc_q + CW'(1);

    mod_counter #(
        .VW(VW)
    ) u_counter (
        .clk_i     (clock),
        .rst_ni    (reset),
        .enable_i  (cnt_en),
        .load_i    (cnt_load),
        .dir_i     (cnt_dir),
        .modulus_i (cnt_mod),
        .value_o   (cnt_value),
        .wrap_o    (cnt_wrap)
    );

    // FSM next state with clear > stop > start priority; the counter is fed
    // the live config while loading on start and the latched config otherwise.
    // Clear zeroes the counter by loading in the up direction.
    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        dir_d    = dir_q;
        mod_d    = mod_q;
        tgt_d    = tgt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_dir  = dir_q;
        cnt_mod  = mod_q;
        if (bus.clear) begin
            state_d  = IDLE;
            wc_d     = '0;
            cnt_load = 1'b1;
            cnt_dir  = 1'b0;
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (bus.modulus > VW'(1)) begin
                            dir_d    = bus.dir;
                            mod_d    = bus.modulus;
                            tgt_d    = bus.wrap_target;
                            wc_d     = '0;
                            cnt_load = 1'b1;
                            cnt_dir  = bus.dir;
                            cnt_mod  = bus.modulus;
                            state_d  = RUN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt_en = 1'b1;
                    if (cnt_wrap) begin
                        wc_d = wc_inc;
                        if ((tgt_q != '0) && (wc_inc == tgt_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.start) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == PAUSE);
    end

    // State, latched configuration and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wc_q    <= '0;
            dir_q   <= 1'b0;
            mod_q   <= '0;
            tgt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            dir_q   <= dir_d;
            mod_q   <= mod_d;
            tgt_q   <= tgt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.value      = cnt_value;
    assign bus.wrap_count = wc_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer with a step-count based reference model.
module tb_count_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic rst_n;

    count_sequencer_if #(.VW(3), .CW(4)) bus ();

    count_sequencer #(.VW(3), .CW(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;
    bit chk_en = 0;

    // Reference model: a run is described by how many steps it has taken.
    int m_mode = M_IDLE;
    int m_steps = 0;
    int m_n = 0;
    int m_dir = 0;
    int m_tgt = 0;
    int m_done = 0;
    int m_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_steps = 0; m_n = 0; m_dir = 0; m_tgt = 0;
            m_done = 0; m_err = 0;
        end else begin
            m_done = 0;
            m_err = 0;
            if (bus.clear) begin
                m_mode = M_IDLE;
                m_steps = 0;
            end else if (bus.stop) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (bus.start && (m_mode == M_IDLE || m_mode == M_DONE)) begin
                if (int'(bus.modulus) >= 2) begin
                    m_n = int'(bus.modulus);
                    m_dir = int'(bus.dir);
                    m_tgt = int'(bus.wrap_target);
                    m_steps = 0;
                    m_mode = M_RUN;
                end else begin
                    m_err = 1;
                end
            end else if (bus.start && m_mode == M_PAUSE) begin
                m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                m_steps++;
                if (m_tgt != 0 && (m_steps / m_n) == m_tgt && (m_steps % m_n) == 0) begin
                    m_mode = M_DONE;
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int ev;
        int ew;
        if (chk_en) begin
            ev = 0;
            ew = 0;
            if (m_mode != M_IDLE) begin
                ev = (m_dir != 0) ? (m_n - 1 - (m_steps % m_n)) : (m_steps % m_n);
                ew = (m_steps / m_n) % 16;
            end
            check("value", int'(bus.value), ev);
            check("wrap_count", int'(bus.wrap_count), ew);
            check("busy", int'(bus.busy), (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0);
            check("done", int'(bus.done), m_done);
            check("err", int'(bus.err), m_err);
            if (bus.done) done_pulses++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic go(input int modv, input int dirv, input int tgtv);
        bus.modulus = 3'(modv);
        bus.dir = dirv[0];
        bus.wrap_target = 4'(tgtv);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.dir = 0;
        bus.modulus = '0; bus.wrap_target = '0;
        rst_n = 1'b0;
        #3;
        check("rst_value", int'(bus.value), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        @(posedge clk); #2;
        chk_en = 1;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // up, N=7, two wraps to completion
        go(7, 0, 2);
        check("t1_start_value", int'(bus.value), 0);
        check("t1_busy", int'(bus.busy), 1);
        done_pulses = 0;
        tick(6);
        check("t1_value6", int'(bus.value), 6);
        tick(1);
        check("t1_wrap1_value", int'(bus.value), 0);
        check("t1_wrap1_count", int'(bus.wrap_count), 1);
        tick(7);
        check("t1_end_value", int'(bus.value), 0);
        check("t1_end_count", int'(bus.wrap_count), 2);
        check("t1_done", int'(bus.done), 1);
        check("t1_busy_low", int'(bus.busy), 0);
        tick(2);
        check("t1_done_pulses", done_pulses, 1);
        check("t1_done_low", int'(bus.done), 0);

        // down, N=5, one wrap, restart from DONE
        go(5, 1, 1);
        check("t2_start_value", int'(bus.value), 4);
        tick(4);
        check("t2_value0", int'(bus.value), 0);
        tick(1);
        check("t2_wrap_value", int'(bus.value), 4);
        check("t2_done", int'(bus.done), 1);
        tick(3);
        check("t2_hold_value", int'(bus.value), 4);
        check("t2_hold_count", int'(bus.wrap_count), 1);

        // pause/resume; config changes mid-run must be ignored
        go(7, 0, 0);
        bus.modulus = 3'd3; bus.dir = 1'b1; bus.wrap_target = 4'd1;
        tick(3);
        check("t3_value3", int'(bus.value), 3);
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
        check("t3_stop_value", int'(bus.value), 3);
        check("t3_pause_busy", int'(bus.busy), 1);
        tick(3);
        check("t3_pause_hold", int'(bus.value), 3);
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        check("t3_resume_edge", int'(bus.value), 3);
        tick(1);
        check("t3_value4", int'(bus.value), 4);
        tick(1);
        check("t3_value5", int'(bus.value), 5);
        bus.start = 1'b1; bus.stop = 1'b1; tick(1);
        bus.start = 1'b0; bus.stop = 1'b0;
        tick(2);
        check("t3_both_paused", int'(bus.value), 5);
        bus.clear = 1'b1; tick(1); bus.clear = 1'b0;
        check("t3_clear_value", int'(bus.value), 0);
        check("t3_clear_busy", int'(bus.busy), 0);

        // rejected start
        go(1, 0, 0);
        check("t4_err", int'(bus.err), 1);
        check("t4_value", int'(bus.value), 0);
        check("t4_busy", int'(bus.busy), 0);
        tick(1);
        check("t4_err_low", int'(bus.err), 0);

        // asynchronous reset mid-run
        go(7, 0, 0);
        tick(5);
        check("t5_value5", int'(bus.value), 5);
        rst_n = 1'b0;
        #1;
        check("t5_rst_value", int'(bus.value), 0);
        check("t5_rst_busy", int'(bus.busy), 0);
        check("t5_rst_count", int'(bus.wrap_count), 0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        check("t5_idle_value", int'(bus.value), 0);
        check("t5_idle_busy", int'(bus.busy), 0);

        // endless run, wrap_count rolls over
        go(2, 0, 0);
        done_pulses = 0;
        tick(30);
        check("t6_count15", int'(bus.wrap_count), 15);
        tick(2);
        check("t6_count_roll", int'(bus.wrap_count), 0);
        tick(8);
        check("t6_count4", int'(bus.wrap_count), 4);
        check("t6_value", int'(bus.value), 0);
        check("t6_no_done", done_pulses, 0);
        bus.clear = 1'b1; tick(1); bus.clear = 1'b0;
        check("t6_clear_value", int'(bus.value), 0);
        check("t6_clear_count", int'(bus.wrap_count), 0);
        check("t6_clear_busy", int'(bus.busy), 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter VW, default 3: width of value and modulus.
REQ-002 SHALL have parameter CW, default 4: width of wrap_count and wrap_target.
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin run from IDLE/DONE; resume from PAUSE.
REQ-006 SHALL have port stop  input  1  pause a run.
REQ-007 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port dir  input  1  0 = count up, 1 = count down.
REQ-009 SHALL have port modulus  input  VW  count modulus N.
REQ-010 SHALL have port wrap_target  input  CW  wraps per run; 0 = endless.
REQ-011 SHALL have port value  output  VW  current count.
REQ-012 SHALL have port wrap_count  output  CW  wraps completed this run.
REQ-013 SHALL have port busy  output  1  high in RUN or PAUSE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-015 SHALL have port err  output  1  one-cycle pulse on rejected start.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-017 SHALL set input priority clear > stop > start in every state.
REQ-018 SHALL, on clear in any state, go to IDLE next edge with value = 0 and wrap_count = 0.
REQ-019 SHALL, on start in IDLE or DONE with modulus >= 2, latch dir, modulus and wrap_target. It SHALL zero wrap_count, load value with 0 (up) or N-1 (down), and enter RUN on the same edge.
REQ-020 SHALL, on start in IDLE or DONE with modulus < 2, stay in the current state, pulse err for one cycle, and leave all other outputs unchanged.
REQ-021 SHALL, in RUN, step value by one each clock: up wraps N-1 -> 0, down wraps 0 -> N-1.
REQ-022 SHALL increment wrap_count on the same edge as each wrap, with CW-bit modulo arithmetic.
REQ-023 SHALL, when wrap_target != 0 and a wrap makes wrap_count equal wrap_target, enter DONE on that edge and assert done during the following cycle only.
REQ-024 SHALL, when wrap_target = 0, never enter DONE; wrap_count wraps freely.
REQ-025 SHALL, on stop in RUN, enter PAUSE and hold value; the stop edge itself SHALL NOT step value.
REQ-026 SHALL, on start in PAUSE, return to RUN; stepping resumes on the following edge.
REQ-027 SHALL, on start and stop together in RUN or PAUSE, take stop (PAUSE).
REQ-028 SHALL, in DONE, hold value and wrap_count until start or clear.
REQ-029 SHALL ignore changes to dir, modulus and wrap_target outside of an accepted start.
REQ-030 SHALL drive all outputs directly from registers.

Reset
REQ-031 SHALL, on reset low, immediately force IDLE, value = 0, wrap_count = 0, busy = 0, done = 0, err = 0, and clear the latched configuration to zero.
REQ-032 SHALL, after reset deasserts mid-run, act only on start; it SHALL NOT resume the prior run.

Structure
REQ-033 SHALL place the state enum (IDLE, RUN, PAUSE, DONE) in package count_seq_pkg.
REQ-034 SHALL place the default widths VW and CW in count_seq_pkg.
REQ-035 SHALL instantiate one sub-module, mod_counter: enable, load, dir and modulus in; value and wrap-pulse out.
REQ-036 SHALL keep the FSM, wrap counting and done/err generation in count_sequencer.

Verification
REQ-037 Bench SHALL cover: modulus=7, dir=0, wrap_target=2, start -> value 0..6,0..6,0; wrap_count 1 then 2; state DONE; one done pulse; busy low after.
REQ-038 Bench SHALL cover: modulus=5, dir=1, wrap_target=1, start -> value 4,3,2,1,0,4; DONE; value holds 4.
REQ-039 Bench SHALL cover: modulus=7 up; stop at value 3; hold 3 cycles; start -> value stays 3 during pause, then 4,5 after resume; start+stop together -> PAUSE.
REQ-040 Bench SHALL cover: modulus=1 start -> err pulse one cycle; state IDLE; value 0.
REQ-041 Bench SHALL cover: reset low mid-RUN at value 5 -> outputs zero immediately, without a clock edge; after release stays IDLE until start.
REQ-042 Bench SHALL cover: wrap_target=0, modulus=2, 40 cycles -> wrap_count wraps 15 -> 0; done never asserts; clear -> IDLE with zeros.
